// File: rtl/vend_item_table_if.sv
// Bus bundle for vend_item_table: APB slave, request/response port and mode select.
interface vend_item_table_if #(
   parameter int ITEM_ADDR_WIDTH = 10,
   parameter int PRICE_WIDTH     = 16,
   parameter int COUNT_WIDTH     = 8
);
   logic                       cfg_mode;
   logic [14:0]                paddr;
   logic                       psel;
   logic                       penable;
   logic                       pwrite;
   logic [31:0]                pwdata;
   logic [31:0]                prdata;
   logic                       pready;
   logic                       pslverr;
   logic                       req_valid;
   logic                       req_ready;
   logic [ITEM_ADDR_WIDTH-1:0] req_item_id;
   logic                       req_dispense;
   logic                       rsp_valid;
   logic [1:0]                 rsp_status;
   logic [PRICE_WIDTH-1:0]     rsp_price;
   logic [COUNT_WIDTH-1:0]     rsp_avail;
   logic                       rsp_low;
   logic                       item_ready;

   modport slave (
      input  cfg_mode, paddr, psel, penable, pwrite, pwdata,
      input  req_valid, req_item_id, req_dispense,
      output prdata, pready, pslverr, req_ready,
      output rsp_valid, rsp_status, rsp_price, rsp_avail, rsp_low, item_ready
   );

   modport master (
      output cfg_mode, paddr, psel, penable, pwrite, pwdata,
      output req_valid, req_item_id, req_dispense,
      input  prdata, pready, pslverr, req_ready,
      input  rsp_valid, rsp_status, rsp_price, rsp_avail, rsp_low, item_ready
   );
endinterface

// File: rtl/vend_item_table.sv
// Vending item table: APB-programmed price/stock/sold store with a 3-cycle query/dispense engine.
// Optional low-stock threshold flag enabled by defining VEND_LOW_STOCK_EN.
module vend_item_table #(
   parameter int MAX_ITEMS       = 1024,
   parameter int ITEM_ADDR_WIDTH = 10,
   parameter int PRICE_WIDTH     = 16,
   parameter int COUNT_WIDTH     = 8
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   vend_item_table_if.slave   io_bus
);
   localparam logic [1:0]             ST_OK       = 2'b00;
   localparam logic [1:0]             ST_INVALID  = 2'b01;
   localparam logic [1:0]             ST_SOLD_OUT = 2'b10;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = 1;
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
   localparam logic [31:0]            MAX_U       = MAX_ITEMS;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_t;
   state_t r_state, w_state_nxt;

   logic [PRICE_WIDTH-1:0]     r_price [MAX_ITEMS];
   logic [COUNT_WIDTH-1:0]     r_avail [MAX_ITEMS];
   logic [COUNT_WIDTH-1:0]     r_sold  [MAX_ITEMS];
   logic [ITEM_ADDR_WIDTH-1:0] r_num_items;
   logic [7:0]                 w_thr;

   logic [ITEM_ADDR_WIDTH-1:0] r_id;
   logic                       r_disp;
   logic [1:0]                 r_rsp_status;
   logic [PRICE_WIDTH-1:0]     r_rsp_price;
   logic [COUNT_WIDTH-1:0]     r_rsp_avail;
   logic [31:0]                r_prdata;
   logic                       r_pready;
   logic                       r_pslverr;

   logic                       w_req_ready;
   logic [12:0]                w_word;
   logic [12:0]                w_item_idx;
   logic [ITEM_ADDR_WIDTH-1:0] w_idx;
   logic                       w_apb_err;
   logic                       w_apb_access;
   logic                       w_apb_wr;
   logic [31:0]                w_rd_data;
   logic                       w_id_valid;
   logic [PRICE_WIDTH-1:0]     w_cur_price;
   logic [COUNT_WIDTH-1:0]     w_cur_avail;
   logic [COUNT_WIDTH-1:0]     w_cur_sold;
   logic                       w_sold_out;
   logic                       w_do_disp;
   logic [COUNT_WIDTH-1:0]     w_new_avail;
   logic [1:0]                 w_status;
   logic                       w_unused_bits;

`ifdef VEND_LOW_STOCK_EN
   logic [7:0] r_thr;
   logic       r_rsp_low;
   logic       w_low;
   assign w_thr = r_thr;
   assign w_low = (w_status == ST_OK) && (r_thr != 8'd0) && (8'(w_new_avail) <= r_thr);
   assign io_bus.rsp_low = r_rsp_low && (r_state == S_RESP);
`else
   assign w_thr          = '0;
   assign io_bus.rsp_low = 1'b0;
`endif

   // Word 0 is NUM_ITEMS; word n+1 is item n.
   assign w_word        = io_bus.paddr[14:2];
   assign w_item_idx    = w_word - 13'd1;
   assign w_idx         = w_item_idx[ITEM_ADDR_WIDTH-1:0];
   assign w_apb_err     = (io_bus.paddr[1:0] != 2'b00) || (32'(w_word) > MAX_U) || !io_bus.cfg_mode;
   assign w_apb_access  = io_bus.psel && io_bus.penable && !r_pready && (r_state == S_IDLE);
   assign w_apb_wr      = w_apb_access && io_bus.pwrite && !w_apb_err;
   assign w_unused_bits = ^{io_bus.pwdata, w_item_idx};

   always_comb begin
      w_rd_data = '0;
      if (w_word == 13'd0) begin
         w_rd_data[ITEM_ADDR_WIDTH-1:0] = r_num_items;
         w_rd_data[31:24]               = w_thr;
      end else if (32'(w_word) <= MAX_U) begin
         w_rd_data[PRICE_WIDTH-1:0] = r_price[w_idx];
         w_rd_data[16 +: COUNT_WIDTH] = r_avail[w_idx];
         w_rd_data[24 +: COUNT_WIDTH] = r_sold[w_idx];
      end
   end

   assign w_id_valid  = (r_id < r_num_items) && (32'(r_id) < MAX_U);
   assign w_cur_price = w_id_valid ? r_price[r_id] : '0;
   assign w_cur_avail = w_id_valid ? r_avail[r_id] : '0;
   assign w_cur_sold  = w_id_valid ? r_sold[r_id]  : '0;
   assign w_sold_out  = r_disp && (w_cur_avail == '0);
   assign w_do_disp   = (r_state == S_LOOKUP) && w_id_valid && r_disp && !w_sold_out;
   assign w_new_avail = (r_disp && !w_sold_out) ? (w_cur_avail - CNT_ONE) : w_cur_avail;

   always_comb begin
      w_status = ST_OK;
      if (!w_id_valid)     w_status = ST_INVALID;
      else if (w_sold_out) w_status = ST_SOLD_OUT;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req_ready = !io_bus.cfg_mode;
            if (io_bus.req_valid && w_req_ready) w_state_nxt = S_LOOKUP;
         end
         S_LOOKUP: w_state_nxt = S_RESP;
         S_RESP:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_IDLE;
         r_id    <= '0;
         r_disp  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && w_req_ready && io_bus.req_valid) begin
            r_id   <= io_bus.req_item_id;
            r_disp <= io_bus.req_dispense;
         end
      end
   end

   // APB writes only commit in IDLE, so they never coincide with a dispense update.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < MAX_ITEMS; i++) begin
            r_price[i] <= '0;
            r_avail[i] <= '0;
            r_sold[i]  <= '0;
         end
         r_num_items <= '0;
`ifdef VEND_LOW_STOCK_EN
         r_thr <= '0;
`endif
      end else begin
         if (w_apb_wr) begin
            if (w_word == 13'd0) begin
               r_num_items <= io_bus.pwdata[ITEM_ADDR_WIDTH-1:0];
`ifdef VEND_LOW_STOCK_EN
               r_thr <= io_bus.pwdata[31:24];
`endif
            end else begin
               r_price[w_idx] <= io_bus.pwdata[PRICE_WIDTH-1:0];
               r_avail[w_idx] <= io_bus.pwdata[16 +: COUNT_WIDTH];
               r_sold[w_idx]  <= '0;
            end
         end
         if (w_do_disp) begin
            r_avail[r_id] <= w_new_avail;
            r_sold[r_id]  <= (w_cur_sold == CNT_MAX) ? CNT_MAX : (w_cur_sold + CNT_ONE);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_rsp_status <= '0;
         r_rsp_price  <= '0;
         r_rsp_avail  <= '0;
`ifdef VEND_LOW_STOCK_EN
         r_rsp_low    <= 1'b0;
`endif
      end else if (r_state == S_LOOKUP) begin
         r_rsp_status <= w_status;
         r_rsp_price  <= w_cur_price;
         r_rsp_avail  <= w_id_valid ? w_new_avail : '0;
`ifdef VEND_LOW_STOCK_EN
         r_rsp_low    <= w_low;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_prdata  <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
      end else if (r_pready) begin
         r_prdata  <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
      end else if (w_apb_access) begin
         r_pready  <= 1'b1;
         r_pslverr <= w_apb_err;
         r_prdata  <= (w_apb_err || io_bus.pwrite) ? 32'd0 : w_rd_data;
      end
   end

   assign io_bus.prdata     = r_prdata;
   assign io_bus.pready     = r_pready;
   assign io_bus.pslverr    = r_pslverr;
   assign io_bus.req_ready  = w_req_ready;
   assign io_bus.rsp_valid  = (r_state == S_RESP);
   assign io_bus.rsp_status = r_rsp_status;
   assign io_bus.rsp_price  = r_rsp_price;
   assign io_bus.rsp_avail  = r_rsp_avail;
   assign io_bus.item_ready = (io_bus.req_item_id < r_num_items);
endmodule
